// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Used by the main FSM and the ALU decoder.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [1:0] OpDp      = 2'b00;
    localparam logic [1:0] OpMem     = 2'b01;
    localparam logic [1:0] OpBranch  = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [1:0] SrcAReg = 2'b00;
    localparam logic [1:0] SrcAPc  = 2'b01;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdOrr = 4'b1100;

    function automatic logic cmd_legal(logic [3:0] cmd);
        return (cmd == CmdAnd) || (cmd == CmdSub) || (cmd == CmdAdd) || (cmd == CmdOrr);
    endfunction

endpackage

// File: rtl/arm_alu_decoder.sv
// Combinational ALU decoder: data-processing cmd/S bit to ALU operation and flag-write intents.
// Outputs ADD with no flag writes whenever disabled or the cmd is unsupported.
module arm_alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       en_i,
    input  logic [3:0] cmd_i,
    input  logic       s_i,
    output logic [1:0] alu_ctrl_o,
    output logic [1:0] flag_w_o,
    output logic       illegal_cmd_o
);

    always_comb begin
        alu_ctrl_o    = AluAdd;
        flag_w_o      = 2'b00;
        illegal_cmd_o = 1'b0;
        if (en_i) begin
            if (cmd_legal(cmd_i)) begin
                unique case (cmd_i)
                    CmdAdd:  alu_ctrl_o = AluAdd;
                    CmdSub:  alu_ctrl_o = AluSub;
                    CmdAnd:  alu_ctrl_o = AluAnd;
                    default: alu_ctrl_o = AluOrr;
                endcase
                // Only arithmetic ops produce meaningful carry/overflow.
                flag_w_o = {s_i, s_i & ((cmd_i == CmdAdd) || (cmd_i == CmdSub))};
            end else begin
                illegal_cmd_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM main control FSM with Moore output ROM and memory wait-state handling.
// Emits raw PCS/RegW/MemW/FlagW intents; conditional-execution gating happens downstream.
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       Illegal
);

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic       dec_en;
    logic [1:0] dec_alu_ctrl;
    logic [1:0] dec_flag_w;
    logic       dec_illegal;

    assign mem_rdy = MEM_WAIT ? MemReady : 1'b1;
    assign dec_en  = (state_q == StExecR) || (state_q == StExecI);

    arm_alu_decoder u_alu_dec (
        .en_i          (dec_en),
        .cmd_i         (Funct[4:1]),
        .s_i           (Funct[0]),
        .alu_ctrl_o    (dec_alu_ctrl),
        .flag_w_o      (dec_flag_w),
        .illegal_cmd_o (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_rdy) state_d = StDecode;
            StDecode: begin
                unique case (Op)
                    OpMem:    state_d = StMemAdr;
                    OpDp:     state_d = Funct[5] ? StExecI : StExecR;
                    OpBranch: state_d = StBranch;
                    default:  state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  if (mem_rdy) state_d = StMemWb;
            StMemWrite: if (mem_rdy) state_d = StFetch;
            StExecR,
            StExecI:    state_d = StAluWb;
            StMemWb,
            StAluWb,
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SrcAReg;
        ALUSrcB    = SrcBReg;
        ResultSrc  = ResAluOut;
        ALUControl = AluAdd;
        FlagW      = 2'b00;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Illegal    = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Reset gating keeps the PC from stepping while the core is held in reset.
                IRWrite   = mem_rdy & reset;
                NextPC    = mem_rdy & reset;
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
            end
            StDecode: begin
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
                Illegal   = (Op == OpIllegal);
            end
            StMemAdr:   ALUSrcB = SrcBImm;
            StMemRead:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = ResData;
                RegW      = 1'b1;
                PCS       = (Rd == 4'hF);
            end
            StMemWrite: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            StExecR,
            StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? SrcBImm : SrcBReg;
                ALUControl = dec_alu_ctrl;
                FlagW      = dec_flag_w;
                Illegal    = dec_illegal;
            end
            StAluWb: begin
                // Funct is still held by the IR, so an unsupported cmd suppresses the write here.
                RegW = cmd_legal(Funct[4:1]);
                PCS  = (Rd == 4'hF);
            end
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAlu;
                PCS       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomized scoreboard bench: each instruction expands into its expected per-cycle
// control outputs, which a negedge monitor compares against the controller.
module tb_arm_mc_controller;

    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       ill;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       IRWrite, NextPC, AdrSrc, PCS, RegW, MemW, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .MemReady   (MemReady),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .Illegal    (Illegal)
    );

    function automatic out_t actual();
        return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW,
                PCS, RegW, MemW, Illegal};
    endfunction

    // Reference: control outputs for a named machine step, straight from the step table.
    function automatic out_t model(string st, bit mr, bit rstn, logic [1:0] op,
                                   logic [5:0] f, logic [3:0] rd);
        out_t       o;
        logic [3:0] cmd;
        bit         known;
        bit         arith;
        logic [1:0] code;
        o     = '0;
        cmd   = f[4:1];
        known = 1'b1;
        arith = 1'b0;
        code  = 2'b00;
        case (cmd)
            4'b0100: begin code = 2'b00; arith = 1'b1; end
            4'b0010: begin code = 2'b01; arith = 1'b1; end
            4'b0000: code = 2'b10;
            4'b1100: code = 2'b11;
            default: known = 1'b0;
        endcase
        if (st == "FETCH") begin
            o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
            o.irw  = mr & rstn; o.npc = mr & rstn;
        end else if (st == "DECODE") begin
            o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
            o.ill  = (op == 2'b11);
        end else if (st == "MEMADR") begin
            o.srcb = 2'b01;
        end else if (st == "MEMREAD") begin
            o.adr = 1'b1;
        end else if (st == "MEMWB") begin
            o.res = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'd15);
        end else if (st == "MEMWRITE") begin
            o.adr = 1'b1; o.memw = 1'b1;
        end else if (st == "EXECR" || st == "EXECI") begin
            o.srcb = (st == "EXECI") ? 2'b01 : 2'b00;
            if (known) begin
                o.alu   = code;
                o.flagw = {f[0], f[0] & arith};
            end else begin
                o.ill = 1'b1;
            end
        end else if (st == "ALUWB") begin
            o.regw = known; o.pcs = (rd == 4'd15);
        end else if (st == "BRANCH") begin
            o.srcb = 2'b01; o.res = 2'b10; o.pcs = 1'b1;
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t  e;
            out_t a;
            e = sb_q.pop_front();
            a = actual();
            n_tests++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (irw npc adr srca srcb res alu flagw pcs regw memw ill)",
                         e.name, a, e.exp);
            end
        end
    end

    task automatic chk(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(string st, bit mr);
        sb_t e;
        MemReady = mr;
        e.name   = st;
        e.exp    = model(st, mr, reset, Op, Funct, Rd);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [1:0] op, logic [5:0] f, logic [3:0] rd, int fw, int mw);
        Op = op; Funct = f; Rd = rd;
        for (int i = 0; i < fw; i++) step("FETCH", 1'b0);
        step("FETCH", 1'b1);
        step("DECODE", 1'($urandom_range(0, 1)));
        case (op)
            2'b00: begin
                step(f[5] ? "EXECI" : "EXECR", 1'($urandom_range(0, 1)));
                step("ALUWB", 1'($urandom_range(0, 1)));
            end
            2'b01: begin
                step("MEMADR", 1'($urandom_range(0, 1)));
                if (f[0]) begin
                    for (int i = 0; i < mw; i++) step("MEMREAD", 1'b0);
                    step("MEMREAD", 1'b1);
                    step("MEMWB", 1'($urandom_range(0, 1)));
                end else begin
                    for (int i = 0; i < mw; i++) step("MEMWRITE", 1'b0);
                    step("MEMWRITE", 1'b1);
                end
            end
            2'b10: step("BRANCH", 1'($urandom_range(0, 1)));
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] cmds [5];
        reset = 1'b0; MemReady = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
        cmds[4] = 4'b1111;
        @(posedge clk);
        #1;
        step("FETCH", 1'b1);
        step("FETCH", 1'b0);
        reset = 1'b1;

        run_instr(2'b00, 6'b001000, 4'd1, 0, 0);   // ADD R1
        run_instr(2'b01, 6'b011001, 4'd2, 2, 3);   // LDR with waits
        run_instr(2'b01, 6'b011000, 4'd3, 0, 2);   // STR with waits
        run_instr(2'b00, 6'b000101, 4'd15, 1, 0);  // SUBS to PC
        run_instr(2'b10, 6'b101000, 4'd0, 0, 0);   // B
        run_instr(2'b11, 6'b000000, 4'd0, 0, 0);   // illegal Op
        run_instr(2'b00, 6'b011110, 4'd4, 0, 0);   // cmd 1111
        run_instr(2'b01, 6'b010001, 4'd15, 0, 1);  // LDR PC

        // Reset while a store is stalled must drop MemW without waiting for a clock.
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
        step("FETCH", 1'b1);
        step("DECODE", 1'b0);
        step("MEMADR", 1'b0);
        step("MEMWRITE", 1'b0);
        MemReady = 1'b1;
        #1;
        chk("memw_before_reset", MemW, 1'b1);
        reset = 1'b0;
        #1;
        chk("memw_async_drop", MemW, 1'b0);
        chk("irwrite_in_reset", IRWrite, 1'b0);
        @(posedge clk);
        #1;
        step("FETCH", 1'b1);
        reset = 1'b1;
        run_instr(2'b00, 6'b101001, 4'd6, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if (op == 2'b00) f[4:1] = cmds[$urandom_range(0, 4)];
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr(op, f, rd, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
